// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   DEFAULT_WIDTH : default operand width in bits
//   mult_state_e  : controller states (IDLE, CALC, DONE)
package seq_mult_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/mult_step.sv
// One shift-and-add iteration, purely combinational.
//   acc         in  2*WIDTH  running partial-product sum
//   mcand       in  2*WIDTH  multiplicand, already shifted to this bit's weight
//   mplier      in  WIDTH    remaining multiplier bits, current bit at [0]
//   acc_next    out 2*WIDTH  acc plus mcand when mplier[0] is set
//   mcand_next  out 2*WIDTH  multiplicand shifted left by one
//   mplier_next out WIDTH    multiplier shifted right by one
module mult_step
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [2*WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0]   mplier_next
);

    // The accumulator is 2*WIDTH wide and the magnitudes are at most WIDTH bits,
    // so this sum can never carry out.
    assign acc_next    = mplier[0] ? (acc + mcand) : acc;
    assign mcand_next  = mcand << 1;
    assign mplier_next = mplier >> 1;

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier, one multiplier bit per cycle, LSB first.
// Signed operands are multiplied as magnitudes and the result negated at the end.
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   in_valid    in   operands and mode presented
//   in_ready    out  block idle and able to accept operands
//   a, b        in   WIDTH-bit multiplicand and multiplier
//   signed_mode in   1 = two's-complement operands, 0 = unsigned
//   out_valid   out  product valid, held until out_ready
//   out_ready   in   consumer accepts product
//   product     out  registered 2*WIDTH-bit result
module seq_shift_add_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    mult_state_e        state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg;
    logic [CNT_W-1:0]   cnt;

    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] mcand_step;
    logic [WIDTH-1:0]   mplier_step;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // -(-2^(WIDTH-1)) wraps back to 1000..0, which read as unsigned is the
    // correct magnitude, so the most-negative operand needs no special case.
    assign a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

    mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (acc_step),
        .mcand_next  (mcand_step),
        .mplier_next (mplier_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            neg     <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        cnt    <= '0;
                        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_step;
                    mcand  <= mcand_step;
                    mplier <= mplier_step;
                    cnt    <= cnt + 1'b1;
                    // Load the product from the final step's sum directly so the
                    // result is visible right after the WIDTH-th CALC edge.
                    if (cnt == LAST_STEP) begin
                        product <= neg ? -acc_step : acc_step;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
module tb_seq_shift_add_mult;

    logic clk;
    logic rst_n;

    // WIDTH = 4 instance
    logic       iv4, ir4, sm4, ov4, or4;
    logic [3:0] a4, b4;
    logic [7:0] p4;

    // WIDTH = 8 instance
    logic        iv8, ir8, sm8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int checks;
    int errors;

    seq_shift_add_mult #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (iv4),
        .in_ready    (ir4),
        .a           (a4),
        .b           (b4),
        .signed_mode (sm4),
        .out_valid   (ov4),
        .out_ready   (or4),
        .product     (p4)
    );

    seq_shift_add_mult #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (iv8),
        .in_ready    (ir8),
        .a           (a8),
        .b           (b8),
        .signed_mode (sm8),
        .out_valid   (ov8),
        .out_ready   (or8),
        .product     (p8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sm;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on the 4-bit DUT, measure edges from acceptance to out_valid,
    // capture the product, then complete the handshake.
    task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic ts,
                        output logic [7:0] prod, output int lat);
        a4 = ta; b4 = tb; sm4 = ts; iv4 = 1'b1; or4 = 1'b0;
        tick();
        iv4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 40) begin
            tick();
            lat++;
        end
        prod = p4;
        or4 = 1'b1;
        tick();
        or4 = 1'b0;
    endtask

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                        output logic [15:0] prod, output int lat);
        a8 = ta; b8 = tb; sm8 = ts; iv8 = 1'b1; or8 = 1'b0;
        tick();
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 40) begin
            tick();
            lat++;
        end
        prod = p8;
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
    endtask

    initial begin
        logic [7:0]  prod4;
        logic [15:0] prod8;
        logic [15:0] exp8;
        int          lat;
        int          ia;
        int          ib;

        checks = 0;
        errors = 0;

        vecs[0] = '{a: 4'hF, b: 4'hF, sm: 1'b0, exp: 8'hE1};  // 15*15 = 225
        vecs[1] = '{a: 4'h8, b: 4'h7, sm: 1'b1, exp: 8'hC8};  // -8*7 = -56
        vecs[2] = '{a: 4'h8, b: 4'h8, sm: 1'b1, exp: 8'h40};  // -8*-8 = 64
        vecs[3] = '{a: 4'h0, b: 4'hD, sm: 1'b0, exp: 8'h00};  // 0*13
        vecs[4] = '{a: 4'h3, b: 4'h5, sm: 1'b0, exp: 8'h0F};  // 3*5 = 15
        vecs[5] = '{a: 4'h3, b: 4'hE, sm: 1'b1, exp: 8'hFA};  // 3*-2 = -6
        vecs[6] = '{a: 4'hF, b: 4'hF, sm: 1'b1, exp: 8'h01};  // -1*-1 = 1
        vecs[7] = '{a: 4'h8, b: 4'h2, sm: 1'b0, exp: 8'h10};  // 8*2 = 16
        vecs[8] = '{a: 4'h7, b: 4'h7, sm: 1'b1, exp: 8'h31};  // 7*7 = 49
        vecs[9] = '{a: 4'hF, b: 4'h0, sm: 1'b0, exp: 8'h00};  // 15*0

        rst_n = 1'b0;
        iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0;
        tick();
        tick();

        check("rst_in_ready4",  32'(ir4), 32'd1);
        check("rst_out_valid4", 32'(ov4), 32'd0);
        check("rst_product4",   32'(p4),  32'd0);
        check("rst_in_ready8",  32'(ir8), 32'd1);
        check("rst_out_valid8", 32'(ov8), 32'd0);
        check("rst_product8",   32'(p8),  32'd0);

        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run4(vecs[i].a, vecs[i].b, vecs[i].sm, prod4, lat);
            check($sformatf("vec%0d_product", i), 32'(prod4), 32'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("vec%0d_idle_after", i), 32'({ir4, ov4}), 32'b10);
        end

        // Backpressure: hold out_ready low, poke in_valid with other operands.
        a4 = 4'h5; b4 = 4'h6; sm4 = 1'b0; iv4 = 1'b1; or4 = 1'b0;
        tick();
        iv4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 40) begin
            tick();
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd4);
        a4 = 4'h1; b4 = 4'h1; sm4 = 1'b1; iv4 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_product_c%0d", c), 32'(p4), 32'h1E);
            check($sformatf("bp_flags_c%0d", c), 32'({ir4, ov4}), 32'b01);
            tick();
        end
        iv4 = 1'b0;
        or4 = 1'b1;
        tick();
        or4 = 1'b0;
        check("bp_release_idle", 32'({ir4, ov4}), 32'b10);

        // Reset in the second CALC cycle aborts the op.
        a4 = 4'h9; b4 = 4'h9; sm4 = 1'b0; iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_out_valid", 32'(ov4), 32'd0);
        check("abort_in_ready",  32'(ir4), 32'd1);
        check("abort_product",   32'(p4),  32'd0);
        lat = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ov4) lat++;
        end
        check("abort_no_emit", 32'(lat), 32'd0);
        run4(4'h6, 4'h7, 1'b0, prod4, lat);
        check("after_abort_product", 32'(prod4), 32'h2A);
        check("after_abort_latency", 32'(lat), 32'd4);

        // WIDTH = 8 corner and randomized pairs against an integer reference.
        run8(8'hFF, 8'hFF, 1'b0, prod8, lat);
        check("w8_ff_ff_product", 32'(prod8), 32'hFE01);
        check("w8_ff_ff_latency", 32'(lat), 32'd8);
        run8(8'h80, 8'h80, 1'b1, prod8, lat);
        check("w8_minneg_sq", 32'(prod8), 32'h4000);

        for (int m = 0; m < 2; m++) begin
            for (int n = 0; n < 1000; n++) begin
                logic [7:0] ra;
                logic [7:0] rb;
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                ia = (m == 1) ? int'($signed(ra)) : int'(ra);
                ib = (m == 1) ? int'($signed(rb)) : int'(rb);
                exp8 = 16'(ia * ib);
                run8(ra, rb, m[0], prod8, lat);
                check($sformatf("w8_rand_m%0d_%0h_%0h", m, ra, rb), 32'(prod8), 32'(exp8));
                check($sformatf("w8_rand_lat_m%0d", m), 32'(lat), 32'd8);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_shift_add_mult.md
SEQ_SHIFT_ADD_MULT -- requirements
Module: seq_shift_add_mult

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset; clk and rst_n are the only clock and reset ports.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  operands and mode presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  multiplicand.
REQ-008 b  input  WIDTH  multiplier.
REQ-009 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 out_valid  output  1  product valid.
REQ-011 out_ready  input  1  consumer accepts product.
REQ-012 product  output  2*WIDTH  registered result.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
REQ-014 IDLE: in_ready=1; on in_valid=1 at a rising edge, the block SHALL latch a, b and signed_mode and go to CALC.
REQ-015 Signed mode: latch |a| and |b|, clear the accumulator, and record neg = a[MSB] XOR b[MSB]; unsigned mode: neg=0.
REQ-016 CALC SHALL run exactly WIDTH cycles, one multiplier bit per cycle, LSB first: if the bit is 1, add the left-shifted multiplicand to the 2*WIDTH accumulator; then shift the multiplier right and the multiplicand left.
REQ-017 A cycle counter (width clog2(WIDTH+1)) SHALL count CALC cycles and move the FSM to DONE after the WIDTH-th step.
REQ-018 On entering DONE, product SHALL be loaded with the accumulator, two's-complement negated to 2*WIDTH bits if neg=1; out_valid=1.
REQ-019 Latency: with operands accepted at edge E0, out_valid SHALL be 1 immediately after edge E0+WIDTH.
REQ-020 DONE: product and out_valid SHALL hold stable until out_valid&out_ready at an edge; the FSM then returns to IDLE and out_valid drops after that edge.
REQ-021 in_ready SHALL be 0 in CALC and DONE; in_valid in those states SHALL be ignored, and latched operands SHALL not change.
REQ-022 Accumulation SHALL be done in 2*WIDTH bits; no overflow is possible, and no bits SHALL be truncated.
REQ-023 Signed most-negative operand (-2^(WIDTH-1)): its magnitude SHALL be handled as an unsigned WIDTH-bit value, giving an exact result.
REQ-024 A zero operand SHALL still take the full WIDTH cycles, giving a constant latency.
REQ-025 Minimum throughput is one result per WIDTH+2 cycles with out_ready held at 1.

Reset
REQ-026 With rst_n=0 at an edge: state=IDLE, in_ready=1, out_valid=0, product=0, counter=0, accumulator=0.
REQ-027 A reset in CALC or DONE SHALL abort the operation; no product SHALL be emitted, and new operands SHALL be accepted on the first edge after rst_n returns to 1.

Structure
REQ-028 The shared package seq_mult_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE) and the default WIDTH constant.
REQ-029 One sub-module, mult_step, SHALL be used: combinational conditional add-and-shift of one iteration, parametrised by WIDTH.

Verification
REQ-030 WIDTH=4, unsigned, a=15, b=15 -> product=0x00E1 (225); out_valid rises 4 edges after acceptance.
REQ-031 WIDTH=4, signed, a=-8 (0x8), b=7 -> product=0xC8 (-56); signed a=-8, b=-8 -> product=0x40 (64).
REQ-032 WIDTH=4, a=0, b=13 -> product=0, with the same latency as nonzero operands.
REQ-033 Backpressure: out_ready=0 for 5 cycles after out_valid -> product stable, in_ready=0, and a new in_valid is ignored; on out_ready=1, IDLE follows.
REQ-034 Reset asserted in the 2nd CALC cycle -> next cycle out_valid=0, in_ready=1, product=0; the following operation is correct.
REQ-035 WIDTH=8, unsigned, a=255, b=255 -> product=0xFE01; randomized 1000 pairs in both modes match the reference product.
